// File: rtl/seg_count_display.sv
// Binary match count -> two BCD digits (serial double-dabble) -> muxed active-low 7-seg; optional SEG_LZ_BLANK_EN blanks a leading tens zero.
// Latency: accept at edge N, display regs/ovf at N+8, LEDs show new value from N+9.
// Backpressure: count_ready is registered, low for 8 cycles after each accept; valid is held by the producer.
module seg_count_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_valid,
  output logic             count_ready,
  output logic [6:0]       LEDs,
  output logic [1:0]       an,
  output logic             ovf
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bin_q, bin_d;
  logic [11:0]      bcd_q, bcd_d, bcd_adj;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic [3:0]       ones_q, ones_d, tens_q, tens_d;
  logic             ovf_q, ovf_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic             digit_sel_q, digit_sel_d;
  logic [6:0]       leds_q, leds_d;
  logic [3:0]       disp_digit;
  logic             wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ready_d   = ready_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    ovf_d     = ovf_q;
    bcd_adj   = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (count_valid) begin
          bin_d     = count_in;
          bcd_d     = '0;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          state_d   = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(CNT_W - 1)) state_d = LATCH;
      end
      LATCH: begin
        ones_d  = bcd_q[3:0];
        tens_d  = bcd_q[7:4];
        ovf_d   = (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] > 4'd9);
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // LEDs follow the next digit_sel so segments and anode switch on the same edge.
  always_comb begin
    wrap        = (refresh_q == RW'(REFRESH_DIV - 1));
    refresh_d   = wrap ? '0 : refresh_q + RW'(1);
    digit_sel_d = wrap ? ~digit_sel_q : digit_sel_q;
    disp_digit  = digit_sel_d ? tens_q : ones_q;
    leds_d      = seg_decode(disp_digit);
    if (ovf_q) leds_d = 7'b1111110;
`ifdef SEG_LZ_BLANK_EN
    else if (digit_sel_d && (tens_q == 4'd0)) leds_d = 7'b1111111;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      ready_q     <= 1'b1;
      ones_q      <= '0;
      tens_q      <= '0;
      ovf_q       <= 1'b0;
      refresh_q   <= '0;
      digit_sel_q <= 1'b0;
      leds_q      <= 7'b0000001;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      ready_q     <= ready_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      ovf_q       <= ovf_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
      leds_q      <= leds_d;
    end
  end

  assign count_ready = ready_q;
  assign LEDs        = leds_q;
  assign ovf         = ovf_q;
  assign an          = digit_sel_q ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_seg_count_display.sv
// Directed bench for seg_count_display with a cycle-level model of the display contract.
module tb_seg_count_display;
  localparam int DIV = 4;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100};
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] count_in = '0;
  logic       count_valid = 1'b0;
  logic       count_ready;
  logic [6:0] LEDs;
  logic [1:0] an;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n_acc  = 0;

  seg_count_display #(.REFRESH_DIV(DIV), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
    .count_ready(count_ready), .LEDs(LEDs), .an(an), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_leds(input int v, input bit sel);
    if (v > 99) return DASH;
    if (sel) begin
      if (LZ && (v / 10 == 0)) return BLANK;
      return SEG_TAB[v / 10];
    end
    return SEG_TAB[v % 10];
  endfunction

  // Model: edges since reset, one conversion in flight, display value and LED source value.
  int m_cyc, m_acc, m_pend, m_disp, m_src;
  bit m_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_acc = 0; m_pend = 0; m_disp = 0; m_src = 0; m_busy = 1'b0;
    end else begin
      m_cyc++;
      m_src = m_disp;
      if (!m_busy && count_valid) begin
        m_busy = 1'b1; m_acc = m_cyc; m_pend = int'(count_in);
      end else if (m_busy && (m_cyc == m_acc + 8)) begin
        m_disp = m_pend; m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) if (!rst && count_valid && count_ready) n_acc++;

  bit cmp_sel;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_sel = ((m_cyc / DIV) % 2) == 1;
      chk("ready", 32'(count_ready), 32'(!m_busy));
      chk("an", 32'(an), cmp_sel ? 32'h1 : 32'h2);
      chk("leds", 32'(LEDs), 32'(exp_leds(m_src, cmp_sel)));
      chk("ovf", 32'(ovf), 32'(m_disp > 99));
    end
  end

  task automatic send(input int v, output int acc);
    int n = 0;
    count_in = 7'(v);
    count_valid = 1'b1;
    while (!count_ready && n < 40) begin @(negedge clk); n++; end
    if (!count_ready) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    acc = m_cyc;
    count_valid = 1'b0;
  endtask

  task automatic wait_sel(input bit s);
    int n = 0;
    logic [1:0] want;
    want = s ? 2'b01 : 2'b10;
    while (an !== want && n < 3 * DIV) begin @(negedge clk); n++; end
    if (an !== want) chk("slot_timeout", 32'(an), 32'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, n0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 32'(count_ready), 32'd1);
    chk("rst_an", 32'(an), 32'h2);
    chk("rst_leds", 32'(LEDs), 32'h01);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    repeat (DIV) @(negedge clk);
    chk("t1_an", 32'(an), 32'h1);
    chk("t1_tens", 32'(LEDs), LZ ? 32'(BLANK) : 32'h01);

    // 42: ready low across CONV+LATCH, then "42"
    send(42, a);
    chk("t2_busy0", 32'(count_ready), 32'd0);
    repeat (7) @(negedge clk);
    chk("t2_busy7", 32'(count_ready), 32'd0);
    @(negedge clk);
    chk("t2_ready", 32'(count_ready), 32'd1);
    @(negedge clk);
    wait_sel(1'b0); chk("t2_ones", 32'(LEDs), 32'b0010010);
    wait_sel(1'b1); chk("t2_tens", 32'(LEDs), 32'b1001100);

    // 127 overflows to dashes, 99 clears it
    send(127, a);
    repeat (9) @(negedge clk);
    chk("t3_ovf1", 32'(ovf), 32'd1);
    wait_sel(1'b0); chk("t3_ones_dash", 32'(LEDs), 32'(DASH));
    wait_sel(1'b1); chk("t3_tens_dash", 32'(LEDs), 32'(DASH));
    send(99, a);
    repeat (9) @(negedge clk);
    chk("t3_ovf0", 32'(ovf), 32'd0);
    wait_sel(1'b0); chk("t3_ones99", 32'(LEDs), 32'b0000100);
    wait_sel(1'b1); chk("t3_tens99", 32'(LEDs), 32'b0000100);

    // 15 presented while 8 converts: accepted on the first IDLE cycle
    n0 = n_acc;
    send(8, a);
    @(negedge clk);
    send(15, b);
    chk("t4_gap", 32'(b - a), 32'd9);
    repeat (9) @(negedge clk);
    chk("t4_accepts", 32'(n_acc - n0), 32'd2);
    wait_sel(1'b0); chk("t4_ones15", 32'(LEDs), 32'b0100100);
    wait_sel(1'b1); chk("t4_tens15", 32'(LEDs), 32'b1001111);

    // reset in the middle of converting 63
    send(63, a);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_ready", 32'(count_ready), 32'd1);
    chk("t5_an", 32'(an), 32'h2);
    chk("t5_leds", 32'(LEDs), 32'h01);
    chk("t5_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_ready_after", 32'(count_ready), 32'd1);
    wait_sel(1'b0); chk("t5_ones0", 32'(LEDs), 32'h01);
    wait_sel(1'b1); chk("t5_tens0", 32'(LEDs), LZ ? 32'(BLANK) : 32'h01);

    // 7: leading zero blank or "07"
    send(7, a);
    repeat (9) @(negedge clk);
    wait_sel(1'b1); chk("t6_tens", 32'(LEDs), LZ ? 32'(BLANK) : 32'h01);
    wait_sel(1'b0); chk("t6_ones", 32'(LEDs), 32'b0001111);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
